// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Buffered UART transmit path. Bus writes with address bit LOGD set push a
//   byte into a synchronous FIFO. An 8N1 serializer drains the FIFO onto the
//   serial line at CLKS_PER_BIT clocks per bit. Frames go out back-to-back
//   while the FIFO has data.
//
// Ports
//   clk          in   system clock, rising edge
//   i_reset      in   synchronous, active-low reset
//   wr_valid     in   bus write strobe (one cycle per write)
//   wr_addr      in   bus write address; only bit LOGD is decoded
//   wr_data      in   [7:0] TX byte; [0] = overflow clear on a control write
//   status       out  {16'b0, count[7:0], 4'b0, overflow, busy, full, empty}
//   uart_rxd_out out  serial TX line, idle high, registered
module uart_tx_queue #(
    parameter int unsigned LOGD         = 7,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] status,
    output logic        uart_rxd_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]         BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    // Serializer
    state_t                r_state;
    logic [CW-1:0]         r_baud;
    logic [7:0]            r_shift;
    logic [2:0]            r_bit_idx;
    logic                  r_line;
    logic [31:0]           r_status;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_boundary;
    logic                  w_push;
    logic                  w_push_full;
    logic                  w_ctrl_clear;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  w_ovf_nxt;
    logic                  w_busy_nxt;
    logic                  w_unused_bits;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_boundary   = (r_baud == BAUD_LAST);

    // Full is judged on the count before this edge, so a concurrent pop
    // does not rescue a write that arrives while full.
    assign w_push       = wr_valid && wr_addr[LOGD] && !w_full;
    assign w_push_full  = wr_valid && wr_addr[LOGD] && w_full;
    assign w_ctrl_clear = wr_valid && !wr_addr[LOGD] && wr_data[0];

    // The serializer pops when idle with data, or at the end of a stop bit
    // with data pending (back-to-back frames).
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_boundary));

    assign w_unused_bits = ^{wr_addr, wr_data[31:8]};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_ovf_nxt = r_overflow;
        if (w_push_full) begin
            w_ovf_nxt = 1'b1;
        end else if (w_ctrl_clear) begin
            w_ovf_nxt = 1'b0;
        end
    end

    // Busy after this edge: state leaves IDLE when a byte is waiting, and
    // returns to IDLE only at a stop-bit boundary with nothing queued.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_busy_nxt = !w_empty;
        end else begin
            w_busy_nxt = !((r_state == S_STOP) && w_boundary && w_empty);
        end
    end

    // FIFO storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_status   <= 32'h0000_0001;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_overflow <= w_ovf_nxt;
            r_status   <= {16'b0, 8'(w_count_nxt), 4'b0, w_ovf_nxt, w_busy_nxt,
                           (w_count_nxt == FULL_CNT), (w_count_nxt == '0)};
        end
    end

    // The line is registered from the state before the edge, so it trails
    // the state by one cycle: a pop at edge N+1 drives the start bit after N+2.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_line    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_line <= 1'b1;
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_line <= 1'b0;
                    if (w_boundary) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    r_line <= r_shift[0];
                    if (w_boundary) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    r_line <= 1'b1;
                    if (w_boundary) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_bit_idx <= '0;
                            r_state   <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_line  <= 1'b1;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    assign status       = r_status;
    assign uart_rxd_out = r_line;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue with CLKS_PER_BIT=4 and a 4-entry FIFO.
// Expected bytes are queued when written; a line monitor decodes frames
// mid-bit and compares them against the queue.
module tb_uart_tx_queue;

    localparam int unsigned CPB = 4;

    logic        clk;
    logic        i_reset;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] status;
    logic        uart_rxd_out;

    int          n_chk;
    int          n_err;
    int          cyc;
    int          epoch;
    logic        mon_en;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    uart_tx_queue #(
        .LOGD(7),
        .CLKS_PER_BIT(CPB),
        .DEPTH_LOG2(2)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .status(status),
        .uart_rxd_out(uart_rxd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the write edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_wr(32'h80, {24'h0, b});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
        check("idle_status", status, 32'h1);
        check("idle_line", {31'h0, uart_rxd_out}, 32'h1);
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        logic seen_low;
        seen_low = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (uart_rxd_out !== 1'b1) seen_low = 1'b1;
        end
        check(tag, {31'h0, seen_low}, 32'h0);
    endtask

    // Line monitor: detect start at a negedge, sample each bit mid-cell.
    initial begin : monitor
        logic [7:0] b;
        logic       sb;
        logic       sp;
        int         ep;
        int         st;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (uart_rxd_out === 1'b0) begin
                ep = epoch;
                st = cyc;
                repeat (2) @(negedge clk);
                sb = uart_rxd_out;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_rxd_out;
                end
                repeat (CPB) @(negedge clk);
                sp = uart_rxd_out;
                if (ep == epoch) begin
                    start_q.push_back(st);
                    check("start_bit", {31'h0, sb}, 32'h0);
                    check("stop_bit", {31'h0, sp}, 32'h1);
                    check("frame_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                    if (exp_q.size() != 0) begin
                        check("rx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        n_chk    = 0;
        n_err    = 0;
        cyc      = 0;
        epoch    = 0;
        mon_en   = 1'b0;
        i_reset  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        // 1. Reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_line", {31'h0, uart_rxd_out}, 32'h1);
        check("reset_status", status, 32'h1);
        i_reset = 1'b1;
        mon_en  = 1'b1;
        idle_watch("reset_idle_line", 50);
        check("reset_idle_status", status, 32'h1);

        // 2. Single byte with latency checks
        start_q.delete();
        tx_byte(8'h55);
        check("push_status", status, 32'h0000_0100);
        @(posedge clk);
        #1;
        check("pop_status", status, 32'h0000_0005);
        check("line_before_start", {31'h0, uart_rxd_out}, 32'h1);
        @(posedge clk);
        #1;
        check("line_start", {31'h0, uart_rxd_out}, 32'h0);
        drain(100);
        check("single_frames", start_q.size(), 1);

        // 3. Burst of five: one pops immediately, four fill the FIFO
        start_q.delete();
        tx_byte(8'hA1);
        tx_byte(8'hB2);
        tx_byte(8'hC3);
        tx_byte(8'hD4);
        tx_byte(8'hE5);
        check("burst_full_status", status, 32'h0000_0406);
        drain(400);
        check("burst_frames", start_q.size(), 5);
        for (int i = 1; i < start_q.size(); i++) begin
            check("burst_gap", start_q[i] - start_q[i-1], 10 * CPB);
        end

        // 4. Overflow while full, then clear
        tx_byte(8'h11);
        tx_byte(8'h22);
        tx_byte(8'h33);
        tx_byte(8'h44);
        tx_byte(8'h88);
        bus_wr(32'h80, 32'h77);
        check("ovf_status", status, 32'h0000_040E);
        bus_wr(32'h0, 32'h1);
        check("ovf_clear_status", status, 32'h0000_0406);
        drain(400);

        // 5. Control-space write is not a push
        bus_wr(32'h0, 32'h5A);
        check("ignored_status", status, 32'h1);
        idle_watch("ignored_line", 50);
        check("ignored_status_after", status, 32'h1);

        // 6. Reset during data bit 3 of 0xF0 (bits 0..3 are zero)
        tx_byte(8'hF0);
        repeat (18) @(posedge clk);
        #1;
        check("mid_bit3_line", {31'h0, uart_rxd_out}, 32'h0);
        epoch++;
        exp_q.delete();
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_line", {31'h0, uart_rxd_out}, 32'h1);
        check("abort_status", status, 32'h1);
        i_reset = 1'b1;
        idle_watch("abort_idle_line", 50);
        tx_byte(8'hA5);
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
